alu_shift_pipe: RTL and testbench
=================================

Name: alu_shift_pipe

Overview:
Parametrised, pipelined shift unit for the NPC execute stage; successor to the single-cycle combinational shifter.
- Supports 64/32-bit (RV64 "W") sll/srl/sra. Word-mode results are sign-extended.
- Shift amount is resolved over a configurable number of register stages.
- Valid/ready handshake on both sides, plus a tag and flush, so it can sit beside a multi-cycle EXU without stalling the whole pipe.

Parameters:
- XLEN, 64, datapath width; power of two, >= 32.
- STAGES, 2, pipeline register stages, 1..$clog2(XLEN).
- TAG_W, 5, width of the opaque tag carried with each operation (e.g. rd index).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  kill all in-flight operations
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept the request this cycle
- in_op  input  3  000 sll, 001 srl, 010 sra, 011 rol, 100 ror; other codes reserved
- in_is32  input  1  word-mode operation
- in_num  input  XLEN  operand
- in_count  input  $clog2(XLEN)  shift amount
- in_tag  input  TAG_W  tag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  XLEN  result
- out_tag  output  TAG_W  tag of the result

Behaviour:
- The clock is clk. Reset is rst: synchronous, active-high.
- Reset clears all stage valid bits. out_valid=0, out_data=0, out_tag=0; in_ready=1 on the first cycle after reset deasserts. Reset mid-operation discards every in-flight op.
- Input accept: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Stage k holds valid_k, the partial result, the remaining count bits, op, is32 and tag. The last stage drives the out_* ports directly from registers.
- Stage k advances when ~valid_{k+1} | advance_{k+1}. The final stage advances on out_ready.
- in_ready = ~flush & (~valid_0 | advance_0). This is combinational from out_ready through the chain; no bubbles at full throughput.
- Latency: exactly STAGES cycles from accept to out_valid when out_ready stays high. Throughput is 1 op/cycle. Capacity is STAGES ops; order is strictly preserved.
- Shift decomposition: the log2(XLEN) binary shift levels are split across the stages, with earlier stages taking the extra level when the split is uneven.
- Right shifts use bit-reverse / left-shift / bit-reverse, as in the current shifter.
- sra fill: a mask is generated at the input and carried down the pipe.
- Word mode (in_is32=1):
  - The operand is the low 32 bits only; effective count is in_count[4:0].
  - sra fills from bit 31. rol/ror rotate within 32 bits.
  - Final result = sign-extend(result[31:0]) to XLEN, for all ops including sll/srl.
- Double-word mode: the full in_count is used; the count is implicitly masked to log2(XLEN) bits.
- Count 0 returns the operand unchanged (still sign-extended in word mode).
- Reserved op codes: accepted normally, result 0, tag passed through.
- flush: on the edge where it is sampled high, all valid bits clear. out_valid=0 the following cycle. While flush=1, in_ready=0, so no op is accepted that cycle. A result presented with out_ready=1 in the flush cycle still counts as transferred.
- While out_valid=1 & out_ready=0, out_data and out_tag hold stable.

Optional Feature:
- Macro: ALU_SHIFT_ROT_EN.
- Defined: op codes 011 (rol) and 100 (ror) perform rotates, implemented by OR-ing the wrapped-out bits. Word mode rotates within 32 bits and then sign-extends.
- Undefined: 011/100 are treated as reserved, giving result 0. The rotate datapath is not synthesised.

Test Plan:
Conditions for all scenarios: XLEN=64, STAGES=2, ALU_SHIFT_ROT_EN defined unless stated.
1. sra, num 0x8000_0000_0000_0000, count 4, out_ready=1 -> out_data 0xF800_0000_0000_0000 exactly 2 cycles after accept, tag preserved.
2. Word mode:
   - srlw, num 0xFFFF_FFFF_8000_0000, count 33 (effective 1) -> 0x0000_0000_4000_0000.
   - sraw, num 0x0000_0000_8000_0000, count 4 -> 0xFFFF_FFFF_F800_0000.
   - sllw, num 0x1, count 31 -> 0xFFFF_FFFF_8000_0000.
3. Back-to-back streaming and backpressure:
   - Stream tags 1..6 of srl num 0xF0, count 4, with out_ready toggling 1,0,0,1,...
   - Required: every result 0x0F, tags emerge 1..6 in order, no loss.
   - in_ready drops only when 2 ops are held and out_ready=0.
4. Flush with 2 ops in flight (out_ready=0) plus in_valid=1 in the flush cycle:
   - out_valid=0 next cycle; the input is not accepted.
   - The next accepted op emerges after 2 cycles with a correct result.
5. Rotate:
   - rol num 0x8000_0000_0000_0001, count 1 -> 0x0000_0000_0000_0003.
   - rorw num 0x0000_0000_0000_0001, count 1 -> 0xFFFF_FFFF_8000_0000.
   - Rebuilt without the macro: both ops -> 0.
6. Reset asserted with ops in flight and out_valid=1 -> next cycle out_valid=0, out_data=0, out_tag=0, in_ready=1 once reset is released.

Source files
------------

// File: rtl/alu_shift_pipe.sv
// -----------------------------------------------------------------------------
// alu_shift_pipe
//
// Pipelined shift unit for the execute stage. It performs 64/32-bit
// sll/srl/sra, and optionally rol/ror. Word-mode results are sign-extended
// from bit 31. The log2(XLEN) binary shift levels are spread over STAGES
// register stages. When the split is uneven, earlier stages take the extra
// level. Each stage carries valid, the partial result, the sra fill mask,
// the count, op flags and the tag. Results leave in strict order.
//
// Right shifts reuse the left shifter as bit-reverse / shift-left /
// bit-reverse. The sra fill mask starts as all-ones at the input. It is
// shifted left alongside the data. At the end it is reversed and inverted,
// which gives the sign-fill bits.
//
// Optional feature macro: ALU_SHIFT_ROT_EN
//   defined   : op 011 = rol and op 100 = ror. A rotate is a shift OR-ed
//               with the bits that wrap out. Word mode rotates within
//               32 bits.
//   undefined : 011/100 are reserved (result 0). No rotate logic is built.
//
// Parameters: XLEN (64), STAGES (2, 1..log2(XLEN)), TAG_W (5)
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 kill all in-flight ops; blocks input that cycle
//   in_valid / in_ready   request handshake
//   in_op                 000 sll, 001 srl, 010 sra, 011 rol, 100 ror
//   in_is32               word-mode operation
//   in_num, in_count      operand and shift amount
//   in_tag                opaque tag carried with the op
//   out_valid / out_ready result handshake
//   out_data, out_tag     registered result and its tag
// -----------------------------------------------------------------------------
module alu_shift_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic                    in_is32,
  input  logic [XLEN-1:0]         in_num,
  input  logic [$clog2(XLEN)-1:0] in_count,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int LOG  = $clog2(XLEN);
  localparam int LAST = STAGES - 1;
  localparam int BASE = LOG / STAGES;
  localparam int REM  = LOG % STAGES;
  localparam logic [LOG-1:0] WORD_CNT_MASK = LOG'(31);

  // First shift level handled by stage k. Earlier stages absorb the remainder.
  function automatic int stage_start(input int k);
    return k * BASE + ((k < REM) ? k : REM);
  endfunction

  function automatic int stage_nlev(input int k);
    return BASE + ((k < REM) ? 1 : 0);
  endfunction

  function automatic logic [XLEN-1:0] rev_x(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
    return r;
  endfunction

  function automatic logic [31:0] rev_w(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

`ifdef ALU_SHIFT_ROT_EN
  // One binary level: shift left by sh. For rotates, OR back in the bits
  // that wrapped out, within 32 bits in word mode. Word-mode counts never
  // reach 32, because the upper count bits are cleared at the input.
  function automatic logic [XLEN-1:0] shift_level(input logic [XLEN-1:0] x,
                                                  input int sh,
                                                  input logic rot,
                                                  input logic is32);
    logic [XLEN-1:0] r;
    logic [31:0]     w;
    r = x << sh;
    w = x[31:0];
    if (rot) begin
      if (is32) begin
        if (sh < 32) r[31:0] = (w << sh) | (w >> (32 - sh));
      end else begin
        r = r | (x >> (XLEN - sh));
      end
    end
    return r;
  endfunction
`else
  function automatic logic [XLEN-1:0] shift_level(input logic [XLEN-1:0] x,
                                                  input int sh);
    return x << sh;
  endfunction
`endif

  // Undo the input reversal for right-type ops, apply the sra fill and
  // sign-extend word results. Word-mode bits above 31 are don't-care until
  // this point.
  function automatic logic [XLEN-1:0] finalize(input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] m,
                                               input logic right,
                                               input logic fill,
                                               input logic is32,
                                               input logic zero);
    logic [XLEN-1:0] r;
    logic [31:0]     w;
    if (is32) begin
      w = right ? rev_w(x[31:0]) : x[31:0];
      if (fill) w = w | ~rev_w(m[31:0]);
      r = {XLEN{w[31]}};
      r[31:0] = w;
    end else begin
      r = right ? rev_x(x) : x;
      if (fill) r = r | ~rev_x(m);
    end
    if (zero) r = '0;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic              valid_q [STAGES];
  logic              valid_d [STAGES];
  logic [XLEN-1:0]   data_q  [STAGES];
  logic [XLEN-1:0]   data_d  [STAGES];
  logic [XLEN-1:0]   mask_q  [STAGES];
  logic [XLEN-1:0]   mask_d  [STAGES];
  logic [LOG-1:0]    cnt_q   [STAGES];
  logic [LOG-1:0]    cnt_d   [STAGES];
  logic              right_q [STAGES];
  logic              right_d [STAGES];
  logic              fill_q  [STAGES];
  logic              fill_d  [STAGES];
  logic              is32_q  [STAGES];
  logic              is32_d  [STAGES];
  logic              zero_q  [STAGES];
  logic              zero_d  [STAGES];
  logic [TAG_W-1:0]  tag_q   [STAGES];
  logic [TAG_W-1:0]  tag_d   [STAGES];
`ifdef ALU_SHIFT_ROT_EN
  logic              rot_q   [STAGES];
  logic              rot_d   [STAGES];
`endif

  logic [STAGES-1:0] load;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  logic            is_sll, is_srl, is_sra;
  logic            prep_right, prep_fill, prep_zero;
  logic [LOG-1:0]  prep_cnt;
  logic [XLEN-1:0] prep_data;
`ifdef ALU_SHIFT_ROT_EN
  logic            is_rol, is_ror, prep_rot;
`endif

  always_comb begin : input_decode
    is_sll     = (in_op == 3'b000);
    is_srl     = (in_op == 3'b001);
    is_sra     = (in_op == 3'b010);
    prep_right = is_srl | is_sra;
    prep_zero  = ~(is_sll | is_srl | is_sra);
`ifdef ALU_SHIFT_ROT_EN
    is_rol     = (in_op == 3'b011);
    is_ror     = (in_op == 3'b100);
    prep_rot   = is_rol | is_ror;
    prep_right = prep_right | is_ror;
    prep_zero  = prep_zero & ~prep_rot;
`endif
    // Word mode only honours count[4:0]. Double-word mode uses the full
    // field, which is already log2(XLEN) bits wide.
    prep_cnt  = in_is32 ? (in_count & WORD_CNT_MASK) : in_count;
    prep_fill = is_sra & (in_is32 ? in_num[31] : in_num[XLEN-1]);
    if (in_is32) begin
      prep_data       = '0;
      prep_data[31:0] = prep_right ? rev_w(in_num[31:0]) : in_num[31:0];
    end else begin
      prep_data = prep_right ? rev_x(in_num) : in_num;
    end
  end

  // ---------------------------------------------------------------------------
  // Advance chain: a stage may load when it is empty or its content moves on.
  // in_ready therefore depends combinationally on out_ready, so the pipe runs
  // at full rate with no bubbles.
  // ---------------------------------------------------------------------------
  always_comb begin : advance_chain
    logic acc;
    acc = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      load[k] = ~valid_q[k] | acc;
      acc     = load[k];
    end
    in_ready = ~flush & load[0];
  end

  // ---------------------------------------------------------------------------
  // Per-stage shift levels
  // ---------------------------------------------------------------------------
  always_comb begin : stage_comb
    logic             s_valid;
    logic [XLEN-1:0]  s_data;
    logic [XLEN-1:0]  s_mask;
    logic [LOG-1:0]   s_cnt;
    logic             s_right;
    logic             s_fill;
    logic             s_is32;
    logic             s_zero;
    logic [TAG_W-1:0] s_tag;
    int               p;
`ifdef ALU_SHIFT_ROT_EN
    logic             s_rot;
`endif
    for (int k = 0; k < STAGES; k++) begin
      p = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        s_valid = in_valid & in_ready;
        s_data  = prep_data;
        s_mask  = '1;
        s_cnt   = prep_cnt;
        s_right = prep_right;
        s_fill  = prep_fill;
        s_is32  = in_is32;
        s_zero  = prep_zero;
        s_tag   = in_tag;
`ifdef ALU_SHIFT_ROT_EN
        s_rot   = prep_rot;
`endif
      end else begin
        s_valid = valid_q[p];
        s_data  = data_q[p];
        s_mask  = mask_q[p];
        s_cnt   = cnt_q[p];
        s_right = right_q[p];
        s_fill  = fill_q[p];
        s_is32  = is32_q[p];
        s_zero  = zero_q[p];
        s_tag   = tag_q[p];
`ifdef ALU_SHIFT_ROT_EN
        s_rot   = rot_q[p];
`endif
      end

      for (int j = 0; j < LOG; j++) begin
        if (j >= stage_start(k) && j < stage_start(k) + stage_nlev(k) && s_cnt[j]) begin
`ifdef ALU_SHIFT_ROT_EN
          s_data = shift_level(s_data, 1 << j, s_rot, s_is32);
`else
          s_data = shift_level(s_data, 1 << j);
`endif
          s_mask = s_mask << (1 << j);
        end
      end

      // The last stage registers the finished result, so out_* come
      // straight from flops.
      if (k == LAST) s_data = finalize(s_data, s_mask, s_right, s_fill, s_is32, s_zero);

      valid_d[k] = flush ? 1'b0 : (load[k] ? s_valid : valid_q[k]);
      data_d[k]  = load[k] ? s_data  : data_q[k];
      mask_d[k]  = load[k] ? s_mask  : mask_q[k];
      cnt_d[k]   = load[k] ? s_cnt   : cnt_q[k];
      right_d[k] = load[k] ? s_right : right_q[k];
      fill_d[k]  = load[k] ? s_fill  : fill_q[k];
      is32_d[k]  = load[k] ? s_is32  : is32_q[k];
      zero_d[k]  = load[k] ? s_zero  : zero_q[k];
      tag_d[k]   = load[k] ? s_tag   : tag_q[k];
`ifdef ALU_SHIFT_ROT_EN
      rot_d[k]   = load[k] ? s_rot   : rot_q[k];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        mask_q[k]  <= '0;
        cnt_q[k]   <= '0;
        right_q[k] <= 1'b0;
        fill_q[k]  <= 1'b0;
        is32_q[k]  <= 1'b0;
        zero_q[k]  <= 1'b0;
        tag_q[k]   <= '0;
`ifdef ALU_SHIFT_ROT_EN
        rot_q[k]   <= 1'b0;
`endif
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        mask_q[k]  <= mask_d[k];
        cnt_q[k]   <= cnt_d[k];
        right_q[k] <= right_d[k];
        fill_q[k]  <= fill_d[k];
        is32_q[k]  <= is32_d[k];
        zero_q[k]  <= zero_d[k];
        tag_q[k]   <= tag_d[k];
`ifdef ALU_SHIFT_ROT_EN
        rot_q[k]   <= rot_d[k];
`endif
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_data  = data_q[LAST];
  assign out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_alu_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_shift_pipe
//
// Directed testbench for alu_shift_pipe (XLEN=64, STAGES=2, TAG_W=5).
// Each test task drives its own vectors and compares them against
// hand-computed results. Rotate expectations follow ALU_SHIFT_ROT_EN.
// -----------------------------------------------------------------------------
module tb_alu_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_is32;
  logic [63:0] in_num;
  logic [5:0]  in_count;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_tag;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_shift_pipe #(.XLEN(64), .STAGES(2), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_is32   (in_is32),
    .in_num    (in_num),
    .in_count  (in_count),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  // One op with out_ready held high. lat counts the accept edge as cycle 1.
  task automatic run_op(input logic [2:0] op, input logic is32, input logic [63:0] num,
                        input logic [5:0] cnt, input logic [4:0] tag,
                        output logic [63:0] data, output logic [4:0] otag, output int lat);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_is32 = is32; in_num = num; in_count = cnt; in_tag = tag;
    out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    data = out_data; otag = out_tag;
    $display("[TB] op=%0d w=%0d num=%h cnt=%0d -> data=%h tag=%0d lat=%0d",
             op, is32, num, cnt, data, otag, lat);
  endtask

  // Two srl ops (0xF0 >> 4) accepted back to back with out_ready low.
  task automatic fill_two(input logic [4:0] t0, input logic [4:0] t1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd1; in_is32 = 1'b0; in_num = 64'hF0; in_count = 6'd4; in_tag = t0;
    @(posedge clk);
    @(negedge clk);
    in_tag = t1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_is32 = 1'b0;
    in_num = '0; in_count = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_data !== 64'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    tests_run++;
    if (out_tag !== 5'h0) begin tests_failed++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_sra_latency();
    logic [63:0] d; logic [4:0] t; int lat;
    run_op(3'd2, 1'b0, 64'h8000_0000_0000_0000, 6'd4, 5'h15, d, t, lat);
    tests_run++;
    if (d !== 64'hF800_0000_0000_0000) begin tests_failed++; $display("FAIL sra_data: got %h expected f800000000000000", d); end
    tests_run++;
    if (t !== 5'h15) begin tests_failed++; $display("FAIL sra_tag: got %h expected 15", t); end
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("FAIL sra_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_dword();
    logic [2:0]  ops  [6];
    logic [63:0] nums [6];
    logic [5:0]  cnts [6];
    logic [63:0] exps [6];
    logic [63:0] d; logic [4:0] t; int lat;
    ops  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd2, 3'd1};
    nums = '{64'h1, 64'h8000_0000_0000_0000, 64'h7000_0000_0000_0000,
             64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0000, 64'hF0};
    cnts = '{6'd63, 6'd63, 6'd4, 6'd0, 6'd63, 6'd4};
    exps = '{64'h8000_0000_0000_0000, 64'h1, 64'h0700_0000_0000_0000,
             64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], 1'b0, nums[i], cnts[i], 5'(i + 1), d, t, lat);
      tests_run++;
      if (d !== exps[i]) begin tests_failed++; $display("FAIL dword_data[%0d]: got %h expected %h", i, d, exps[i]); end
      tests_run++;
      if (t !== 5'(i + 1)) begin tests_failed++; $display("FAIL dword_tag[%0d]: got %0d expected %0d", i, t, i + 1); end
    end
  endtask

  task automatic test_word_mode();
    logic [2:0]  ops  [6];
    logic [63:0] nums [6];
    logic [5:0]  cnts [6];
    logic [63:0] exps [6];
    logic [63:0] d; logic [4:0] t; int lat;
    ops  = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd1, 3'd2};
    nums = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 64'h1,
             64'hFFFF_FFFF_0000_0001, 64'h0000_0000_8000_0001, 64'h0000_0000_7FFF_FFFF};
    cnts = '{6'd33, 6'd4, 6'd31, 6'd32, 6'd0, 6'd36};
    exps = '{64'h0000_0000_4000_0000, 64'hFFFF_FFFF_F800_0000, 64'hFFFF_FFFF_8000_0000,
             64'h1, 64'hFFFF_FFFF_8000_0001, 64'h0000_0000_07FF_FFFF};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], 1'b1, nums[i], cnts[i], 5'(i + 10), d, t, lat);
      tests_run++;
      if (d !== exps[i]) begin tests_failed++; $display("FAIL word_data[%0d]: got %h expected %h", i, d, exps[i]); end
    end
  endtask

  task automatic test_rotate();
    logic [2:0]  ops  [4];
    logic        w32  [4];
    logic [63:0] nums [4];
    logic [63:0] exps [4];
    logic [63:0] d; logic [4:0] t; int lat;
    ops  = '{3'd3, 3'd4, 3'd4, 3'd3};
    w32  = '{1'b0, 1'b1, 1'b0, 1'b1};
    nums = '{64'h8000_0000_0000_0001, 64'h1, 64'h1, 64'h0000_0000_8000_0000};
`ifdef ALU_SHIFT_ROT_EN
    exps = '{64'h3, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000_0000_0000, 64'h1};
`else
    exps = '{64'h0, 64'h0, 64'h0, 64'h0};
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], w32[i], nums[i], 6'd1, 5'(i + 20), d, t, lat);
      tests_run++;
      if (d !== exps[i]) begin tests_failed++; $display("FAIL rotate_data[%0d]: got %h expected %h", i, d, exps[i]); end
      tests_run++;
      if (t !== 5'(i + 20)) begin tests_failed++; $display("FAIL rotate_tag[%0d]: got %0d expected %0d", i, t, i + 20); end
    end
  endtask

  task automatic test_reserved();
    logic [63:0] d; logic [4:0] t; int lat;
    for (int i = 5; i < 8; i++) begin
      run_op(3'(i), 1'b0, 64'hFF, 6'd1, 5'(i + 24), d, t, lat);
      tests_run++;
      if (d !== 64'h0) begin tests_failed++; $display("FAIL reserved_data[%0d]: got %h expected 0", i, d); end
      tests_run++;
      if (t !== 5'(i + 24)) begin tests_failed++; $display("FAIL reserved_tag[%0d]: got %0d expected %0d", i, t, i + 24); end
    end
  endtask

  task automatic test_back_to_back();
    int  sent = 0, rcvd = 0, held = 0, c = 0;
    logic acc, xf, exp_ready;
    while (rcvd < 6 && c < 100) begin
      @(negedge clk);
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      in_valid  = (sent < 6);
      in_op = 3'd1; in_is32 = 1'b0; in_num = 64'hF0; in_count = 6'd4; in_tag = 5'(sent + 1);
      #1;
      exp_ready = !(held == 2 && !out_ready);
      tests_run++;
      if (in_ready !== exp_ready) begin
        tests_failed++; $display("FAIL b2b_in_ready[c%0d]: got %b expected %b", c, in_ready, exp_ready);
      end
      acc = in_valid && in_ready;
      xf  = out_valid && out_ready;
      if (xf) begin
        $display("[TB] b2b cycle=%0d result data=%h tag=%0d", c, out_data, out_tag);
        tests_run++;
        if (out_data !== 64'h0F) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h expected f", rcvd, out_data); end
        tests_run++;
        if (out_tag !== 5'(rcvd + 1)) begin tests_failed++; $display("FAIL b2b_tag[%0d]: got %0d expected %0d", rcvd, out_tag, rcvd + 1); end
        rcvd++;
      end
      if (acc) sent++;
      held = held + (acc ? 1 : 0) - (xf ? 1 : 0);
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (rcvd !== 6) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 6", rcvd); end
  endtask

  task automatic test_flush();
    logic [63:0] d; logic [4:0] t; int lat; int seen;
    fill_two(5'd7, 5'd8);
    tests_run++;
    if (out_valid !== 1'b1 || out_tag !== 5'd7) begin
      tests_failed++; $display("FAIL flush_prefill: got valid=%b tag=%0d expected valid=1 tag=7", out_valid, out_tag);
    end
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_is32 = 1'b0; in_num = 64'h5; in_count = 6'd1; in_tag = 5'd9;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin tests_failed++; $display("FAIL flush_no_leak: got %0d results expected 0", seen); end
    run_op(3'd1, 1'b0, 64'hF0, 6'd4, 5'd10, d, t, lat);
    tests_run++;
    if (d !== 64'h0F || t !== 5'd10) begin
      tests_failed++; $display("FAIL flush_next_op: got data=%h tag=%0d expected data=f tag=10", d, t);
    end
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("FAIL flush_next_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_reset_midflight();
    fill_two(5'd11, 5'd12);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 64'h0F) begin
      tests_failed++; $display("FAIL rst_prefill: got valid=%b data=%h expected valid=1 data=f", out_valid, out_data);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_data !== 64'h0) begin tests_failed++; $display("FAIL rst_mid_out_data: got %h expected 0", out_data); end
    tests_run++;
    if (out_tag !== 5'h0) begin tests_failed++; $display("FAIL rst_mid_out_tag: got %0d expected 0", out_tag); end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_leak: got %b expected 0", out_valid); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sra_latency();
    test_dword();
    test_word_mode();
    test_rotate();
    test_reserved();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
